bsg_manycore_fsb_master_link: RTL

- Master-side endpoint of the FSB ring for one exposed manycore link; the peer of the client-side links-to-FSB converter.
- Host side: accepts manycore packets, wraps them into FSB ring words and sends them to the client node.
- Enforces the client's remote-credit limit.
- Delivers client-originated packets to the host and returns one credit word per consumed packet.

---
 rtl/bsg_manycore_fsb_master_link_if.sv | 39 +++
 rtl/bsg_manycore_fsb_master_link.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_fsb_master_link_if.sv
// Ring and host handshake bundle for the FSB master link.
// master = link endpoint, slave = ring/host environment.
`timescale 1ns/1ps
interface bsg_manycore_fsb_master_link_if #(
  parameter int ring_width_p = 80,
  parameter int pkt_width_p  = 64,
  parameter int cred_width_p = 3
);
  logic                    v_i;
  logic [ring_width_p-1:0] data_i;
  logic                    ready_o;
  logic                    v_o;
  logic [ring_width_p-1:0] data_o;
  logic                    yumi_i;
  logic                    out_v_i;
  logic [pkt_width_p-1:0]  out_pkt_i;
  logic                    out_ready_o;
  logic                    in_v_o;
  logic [pkt_width_p-1:0]  in_pkt_o;
  logic                    in_yumi_i;
  logic [cred_width_p-1:0] credits_o;
  logic                    error_o;

  modport master (
    input  v_i, data_i, yumi_i,
    input  out_v_i, out_pkt_i, in_yumi_i,
    output ready_o, v_o, data_o,
    output out_ready_o, in_v_o, in_pkt_o,
    output credits_o, error_o
  );

  modport slave (
    output v_i, data_i, yumi_i,
    output out_v_i, out_pkt_i, in_yumi_i,
    input  ready_o, v_o, data_o,
    input  out_ready_o, in_v_o, in_pkt_o,
    input  credits_o, error_o
  );
endinterface

// File: rtl/bsg_manycore_fsb_master_link.sv
// FSB master endpoint for one manycore link: credit-limited
// host->ring sender plus ring->host receiver with credit return.
`timescale 1ns/1ps
module bsg_manycore_fsb_master_link #(
  parameter int ring_width_p     = 80,
  parameter int pkt_width_p      = 64,
  parameter int master_id_p      = 0,
  parameter int client_id_p      = 1,
  parameter int link_id_p        = 0,
  parameter int tag_width_p      = 4,
  parameter int remote_credits_p = 4
) (
  input logic clk_i,
  input logic reset_n_i,
  input logic en_i,
  bsg_manycore_fsb_master_link_if.master link
);

  localparam int cw = $clog2(remote_credits_p + 1);
  localparam int tw = tag_width_p;
  localparam int pw = pkt_width_p;
  localparam int rw = ring_width_p;

  localparam logic [3:0] mid = 4'(master_id_p);
  localparam logic [3:0] cid = 4'(client_id_p);
  localparam logic [tw-2:0] lid = (tw-1)'(link_id_p);
  localparam logic [cw-1:0] cmax = cw'(remote_credits_p);

  typedef enum logic [1:0] {
    EMPTY,
    DATA,
    CREDIT
  } state_e;

  state_e state;
  logic          v_r;
  logic [rw-1:0] data_r;
  logic [cw-1:0] credits;
  logic [cw-1:0] pend;
  logic [cw-1:0] pend_rem;
  logic          err_r;

  logic [pw-1:0] mem [2];
  logic          wp;
  logic          rp;
  logic [1:0]    cnt;

  logic          full;
  logic          empty;
  logic          ready;
  logic          pop;

  logic [3:0]    rx_dest;
  logic          rx_cmd;
  logic [tw-1:0] rx_tag;
  logic          rx_acc;
  logic          rx_bad;
  logic          rx_cred;
  logic          rx_push;

  logic          free;
  logic          cred_ack;
  logic          out_ready;
  logic          host_acc;
  logic          cred_ovf;

  logic [rw-1:0] data_word;
  logic [rw-1:0] cred_word;
  logic          unused_data;

  assign rx_dest = link.data_i[rw-1 -: 4];
  assign rx_cmd  = link.data_i[rw-5];
  assign rx_tag  = link.data_i[pw +: tw];
  assign unused_data = ^link.data_i[rw-6 : pw+tw];

  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);
  assign ready = reset_n_i & ~full;
  assign pop   = link.in_yumi_i & ~empty;

  assign rx_acc  = link.v_i & ready;
  assign rx_bad  = (rx_dest != mid) | rx_cmd
                 | (rx_tag[tw-1:1] != lid);
  assign rx_cred = rx_acc & ~rx_bad & rx_tag[0];
  assign rx_push = rx_acc & ~rx_bad & ~rx_tag[0];

  // A credit word accepted this cycle no longer counts as pending,
  // so data may follow it with no bubble.
  assign cred_ack  = v_r & link.yumi_i & (state == CREDIT);
  assign pend_rem  = pend - cw'(cred_ack);
  assign free      = (state == EMPTY) | link.yumi_i;
  assign out_ready = en_i & (credits != '0) & free
                   & (pend_rem == '0);
  assign host_acc  = link.out_v_i & out_ready;
  assign cred_ovf  = rx_cred & ~host_acc & (credits == cmax);

  always_comb begin
    data_word = '0;
    data_word[rw-1 -: 4] = cid;
    data_word[pw +: tw] = {lid, 1'b0};
    data_word[pw-1:0] = link.out_pkt_i;
    cred_word = '0;
    cred_word[rw-1 -: 4] = cid;
    cred_word[pw +: tw] = {lid, 1'b1};
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state  <= EMPTY;
      v_r    <= 1'b0;
      data_r <= '0;
    end else if (free) begin
      unique case (1'b1)
        (pend_rem != '0): begin
          state  <= CREDIT;
          v_r    <= 1'b1;
          data_r <= cred_word;
        end
        host_acc: begin
          state  <= DATA;
          v_r    <= 1'b1;
          data_r <= data_word;
        end
        pop: begin
          state  <= CREDIT;
          v_r    <= 1'b1;
          data_r <= cred_word;
        end
        default: begin
          state  <= EMPTY;
          v_r    <= 1'b0;
          data_r <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      credits <= cmax;
      pend    <= '0;
      err_r   <= 1'b0;
    end else begin
      if (host_acc & ~rx_cred)
        credits <= credits - 1'b1;
      else if (rx_cred & ~host_acc & (credits != cmax))
        credits <= credits + 1'b1;
      pend <= pend_rem + cw'(pop);
      if ((rx_acc & rx_bad) | cred_ovf)
        err_r <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (rx_push) begin
        mem[wp] <= link.data_i[pw-1:0];
        wp      <= ~wp;
      end
      if (pop)
        rp <= ~rp;
      cnt <= cnt + {1'b0, rx_push} - {1'b0, pop};
    end
  end

  assign link.ready_o     = ready;
  assign link.v_o         = v_r;
  assign link.data_o      = data_r;
  assign link.out_ready_o = out_ready;
  assign link.in_v_o      = ~empty;
  assign link.in_pkt_o    = mem[rp];
  assign link.credits_o   = credits;
  assign link.error_o     = err_r;

endmodule
